// File: rtl/handshake_coeff_arbiter.sv
// Shares one fixed 12-bit softclip coefficient table between two requesters
// through a round-robin grant and a one-entry registered output stage (1 cycle).
// Optional HANDSHAKE_COEFF_ARB_IDX_CHECK_EN adds a sticky out-of-range flag err_idx.
module handshake_coeff_arbiter #(
  parameter int DATA_WIDTH  = 12,
  parameter int IDX_WIDTH   = 3,
  parameter int NUM_ENTRIES = 5
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [IDX_WIDTH-1:0]  req0_idx,
  input  logic                  req0_valid,
  output logic                  req0_ready,
  input  logic [IDX_WIDTH-1:0]  req1_idx,
  input  logic                  req1_valid,
  output logic                  req1_ready,
  output logic [DATA_WIDTH-1:0] outs,
  output logic                  outs_tag,
  output logic                  outs_valid,
  input  logic                  outs_ready
`ifdef HANDSHAKE_COEFF_ARB_IDX_CHECK_EN
  ,
  output logic                  err_idx
`endif
);

  logic                 full;
  logic                 last;
  logic                 accept;
  logic                 grant0;
  logic                 grant1;
  logic                 xfer0;
  logic                 xfer1;
  logic                 xfer;
  logic [IDX_WIDTH-1:0] sel_idx;

  // Fixed table; anything at or beyond NUM_ENTRIES reads as zero.
  function automatic logic [DATA_WIDTH-1:0] coeff_lookup(input logic [IDX_WIDTH-1:0] idx);
    logic [DATA_WIDTH-1:0] val;
    case (idx)
      IDX_WIDTH'(1): val = DATA_WIDTH'(12'h0CE);
      IDX_WIDTH'(2): val = DATA_WIDTH'(12'h32A);
      IDX_WIDTH'(3): val = DATA_WIDTH'(12'h7FF);
      IDX_WIDTH'(4): val = DATA_WIDTH'(12'hF32);
      default:       val = '0;
    endcase
    if (int'(idx) >= NUM_ENTRIES) begin
      val = '0;
    end
    return val;
  endfunction

  // Round-robin grant: on a tie the requester not served last wins; the
  // stage accepts when empty or when its current token drains this cycle.
  always_comb begin
    accept     = !full || outs_ready;
    grant0     = req0_valid && (!req1_valid || last);
    grant1     = req1_valid && (!req0_valid || !last);
    req0_ready = accept && grant0;
    req1_ready = accept && grant1;
    xfer0      = req0_valid && req0_ready;
    xfer1      = req1_valid && req1_ready;
    xfer       = xfer0 || xfer1;
    sel_idx    = xfer1 ? req1_idx : req0_idx;
  end

  // Output stage and priority pointer; the pointer only moves on a real transfer.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      full     <= 1'b0;
      outs     <= '0;
      outs_tag <= 1'b0;
      last     <= 1'b1;
    end else if (xfer) begin
      outs     <= coeff_lookup(sel_idx);
      outs_tag <= xfer1;
      full     <= 1'b1;
      last     <= xfer1;
    end else if (outs_ready) begin
      full     <= 1'b0;
    end
  end

  assign outs_valid = full;

`ifdef HANDSHAKE_COEFF_ARB_IDX_CHECK_EN
  // Sticky flag for any accepted index outside the table.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      err_idx <= 1'b0;
    end else if (xfer && (int'(sel_idx) >= NUM_ENTRIES)) begin
      err_idx <= 1'b1;
    end
  end
`endif

endmodule
